regfile_write_scheduler: RTL

- Shares the register file's single write port between the pipeline writeback stage (WB) and the long-latency unit (LU, mul/div).
- Keeps a 32-entry busy scoreboard of pending destination registers, and stalls decode on RAW/WAW hazards or when LU capacity is full.
- Sits between decode/WB/LU and the Registers block; drives regWrite, writeReg and writeData directly.

---
 rtl/regfile_write_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_scheduler.sv
// Write-port arbiter between writeback and the long-latency unit, with a
// busy scoreboard that stalls decode on RAW/WAW hazards or a full LU.
module regfile_write_scheduler #(
  parameter int LU_DEPTH    = 4,
  parameter int LU_MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic [4:0]  issue_rd,
  input  logic        issue_long,
  output logic        stall,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        wb_ready,
  input  logic        lu_valid,
  input  logic [4:0]  lu_reg,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        regWrite,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic [31:0] busy_mask
);

  localparam logic [3:0] DEPTH_C = 4'(LU_DEPTH);
  localparam logic [3:0] MAX_C   = 4'(LU_MAX_WAIT);

  logic [31:0] busy_r;
  logic [3:0]  lu_cnt_r;
  logic [3:0]  wait_cnt_r;

  logic        force_s;
  logic        hazard_s;
  logic        accept_s;
  logic        lu_dec_s;
  logic [31:0] clr_vec_s;
  logic [31:0] busy_eff_s;
  logic [31:0] set_vec_s;

  // Arbitration, write-port mux, hazard detection and scoreboard update vectors
  always_comb begin
    force_s  = lu_valid & (wait_cnt_r == MAX_C);
    lu_ready = ~reset & lu_valid & (~wb_valid | force_s);
    wb_ready = ~reset & wb_valid & ~force_s;

    if (wb_ready) begin
      writeReg  = wb_reg;
      writeData = wb_data;
    end else if (lu_ready) begin
      writeReg  = lu_reg;
      writeData = lu_data;
    end else begin
      writeReg  = 5'd0;
      writeData = 32'd0;
    end

    regWrite = (wb_ready | lu_ready) & (writeReg != 5'd0);

    if (regWrite) begin
      clr_vec_s = 32'd1 << writeReg;
    end else begin
      clr_vec_s = 32'd0;
    end

    // A register committing this cycle is already readable via the negedge write
    busy_eff_s = busy_r & ~clr_vec_s & ~32'd1;
    hazard_s   = busy_eff_s[issue_rs] | busy_eff_s[issue_rt] | busy_eff_s[issue_rd];

    if (reset) begin
      stall = 1'b1;
    end else begin
      stall = issue_valid &
              (hazard_s | (issue_long & (lu_cnt_r == DEPTH_C) & ~lu_ready));
    end

    accept_s = ~reset & issue_valid & ~stall;
    lu_dec_s = lu_ready & (lu_cnt_r != 4'd0);

    if (accept_s && (issue_rd != 5'd0)) begin
      set_vec_s = 32'd1 << issue_rd;
    end else begin
      set_vec_s = 32'd0;
    end
  end

  // Scoreboard, LU occupancy and LU starvation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r     <= 32'd0;
      lu_cnt_r   <= 4'd0;
      wait_cnt_r <= 4'd0;
    end else begin
      busy_r <= (busy_r & ~clr_vec_s) | set_vec_s;

      case ({accept_s & issue_long, lu_dec_s})
        2'b10:   lu_cnt_r <= lu_cnt_r + 4'd1;
        2'b01:   lu_cnt_r <= lu_cnt_r - 4'd1;
        default: lu_cnt_r <= lu_cnt_r;
      endcase

      if (lu_valid && !lu_ready) begin
        if (wait_cnt_r < MAX_C) begin
          wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
          wait_cnt_r <= wait_cnt_r;
        end
      end else begin
        wait_cnt_r <= 4'd0;
      end
    end
  end

  assign busy_mask = busy_r;

  regfile_write_scheduler_chk #(
    .LU_DEPTH (LU_DEPTH)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .wb_ready (wb_ready),
    .lu_ready (lu_ready),
    .lu_cnt   (lu_cnt_r)
  );

endmodule

// Protocol checks: exclusive grants, no LU completion without an outstanding op.
module regfile_write_scheduler_chk #(
  parameter int LU_DEPTH = 4
) (
  input logic       clk,
  input logic       reset,
  input logic       wb_ready,
  input logic       lu_ready,
  input logic [3:0] lu_cnt
);

  grant_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(wb_ready && lu_ready));

  lu_ready_needs_op: assert property (@(posedge clk) disable iff (reset)
    !(lu_ready && (lu_cnt == 4'd0)));

  lu_cnt_bounded: assert property (@(posedge clk) disable iff (reset)
    (lu_cnt <= 4'(LU_DEPTH)));

endmodule
